// File: rtl/mem_io_ctrl.sv
// mem_io_ctrl: program/data RAM, LED register, load port and run sequencer.
// Optional retired-instruction counter is built when INSTR_COUNT_EN is defined.
module mem_io_ctrl #(
  parameter int          ADDR_BITS = 7,
  parameter int          DATA_W    = 16,
  parameter logic [15:0] LED_ADDR  = 16'h1000,
  parameter int          RUN_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          proc_addr,
  input  logic [DATA_W-1:0]    proc_dout,
  input  logic                 proc_mem_write,
  input  logic                 proc_din_sel,
  input  logic [15:0]          proc_pc,
  input  logic                 proc_done,
  input  logic                 load_mode,
  input  logic                 load_we,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic [DATA_W-1:0]    load_data,
  output logic [DATA_W-1:0]    din,
  output logic                 run,
  output logic [DATA_W-1:0]    leds,
  output logic                 halted,
  output logic [15:0]          instr_count
);

  localparam int DEPTH = 2 ** ADDR_BITS;
  localparam int CW    = (RUN_DELAY > 1) ? $clog2(RUN_DELAY) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_WAIT,
    S_RUN,
    S_HALT
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   din_q, din_d;
  logic [DATA_W-1:0]   leds_q, leds_d;
  logic [3:0]          op_q, op_d;
  logic [15:0]         ra;
  logic                ra_ram;
  logic                pa_ram;
  logic                in_run;
  logic                in_load;
  logic                mem_we;
  logic [ADDR_BITS-1:0] mem_wa;
  logic [DATA_W-1:0]   mem_wd;

  assign ra      = proc_din_sel ? proc_addr : proc_pc;
  assign ra_ram  = ra[15:ADDR_BITS] == '0;
  assign pa_ram  = proc_addr[15:ADDR_BITS] == '0;
  assign in_run  = state_q == S_RUN;
  assign in_load = state_q == S_LOAD;

  // Read sees pre-write RAM and LED contents.
  always_comb begin
    din_d = '0;
    unique case (1'b1)
      ra_ram:           din_d = mem[ra[ADDR_BITS-1:0]];
      (ra == LED_ADDR): din_d = leds_q;
      default:          din_d = '0;
    endcase
  end

  always_comb begin
    op_d = op_q;
    if (!proc_din_sel) begin
      op_d = din_d[DATA_W-1 -: 4];
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_wa = load_addr;
    mem_wd = load_data;
    leds_d = leds_q;
    if (in_load && load_we) begin
      mem_we = 1'b1;
    end else if (in_run && proc_mem_write) begin
      if (pa_ram) begin
        mem_we = 1'b1;
        mem_wa = proc_addr[ADDR_BITS-1:0];
        mem_wd = proc_dout;
      end else if (proc_addr == LED_ADDR) begin
        leds_d = proc_dout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_mode) begin
      state_d = S_LOAD;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_LOAD: begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
        S_WAIT: begin
          if (cnt_q == CW'(RUN_DELAY - 1)) begin
            state_d = S_RUN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RUN: begin
          if (proc_done && op_q == 4'hB) begin
            state_d = S_HALT;
          end
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_LOAD;
      endcase
    end
  end

  // Reset lands directly in LOAD when a program load is pending.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= load_mode ? S_LOAD : S_WAIT;
      cnt_q   <= '0;
      din_q   <= '0;
      leds_q  <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      leds_q  <= leds_d;
      op_q    <= op_d;
    end
  end

`ifdef INSTR_COUNT_EN
  logic [15:0] ic_q, ic_d;

  always_comb begin
    ic_d = ic_q;
    if (state_d == S_LOAD && !in_load) begin
      ic_d = '0;
    end else if (in_run && proc_done && ic_q != 16'hFFFF) begin
      ic_d = ic_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ic_q <= '0;
    end else begin
      ic_q <= ic_d;
    end
  end

  assign instr_count = ic_q;
`else
  assign instr_count = 16'h0;
`endif

  assign din    = din_q;
  assign leds   = leds_q;
  assign run    = in_run;
  assign halted = state_q == S_HALT;

endmodule
